// File: rtl/m_ifetch_queue_if.sv
// Bundle of the fetch-unit signals: imem request/response plus the ID-stage valid/ready side.
// The master modport is the fetch queue; the slave modport is whatever sits around it.
interface m_ifetch_queue_if #(
   parameter int AW    = 12,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0] w_imem_addr;
   logic          w_imem_rd;
   logic [31:0]   w_imem_data;
   logic          w_redirect;
   logic [31:0]   w_redirect_pc;
   logic          w_halt;
   logic          w_ready;
   logic          r_valid;
   logic [31:0]   r_ir;
   logic [31:0]   r_pc;
   logic [31:0]   r_pc4;
   logic [CW-1:0] r_count;

   modport master (
      output w_imem_addr, w_imem_rd, r_valid, r_ir, r_pc, r_pc4, r_count,
      input  w_imem_data, w_redirect, w_redirect_pc, w_halt, w_ready
   );

   modport slave (
      input  w_imem_addr, w_imem_rd, r_valid, r_ir, r_pc, r_pc4, r_count,
      output w_imem_data, w_redirect, w_redirect_pc, w_halt, w_ready
   );
endinterface

// File: rtl/m_ifetch_queue.sv
// Fetch PC generator and instruction queue feeding the ID stage over valid/ready.
// Optional macro IFETCH_BYPASS_EN: an empty queue forwards a returning fetch combinationally.
module m_ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          AW       = 12
) (
   input logic              w_clk,
   input logic              w_rst,
   m_ifetch_queue_if.master fq
);
   localparam int          PW  = $clog2(DEPTH);
   localparam int          CW  = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0020;

   logic [31:0]   fetch_pc;
   logic          inflight;
   logic          kill;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [31:0]   last_pc;
   logic [31:0]   last_pc4;

   logic [31:0]   ir_q  [DEPTH];
   logic [31:0]   pc_q  [DEPTH];
   logic [31:0]   pc4_q [DEPTH];

   logic          issue;
   logic          ret_valid;
   logic          bypass;
   logic          q_nonempty;
   logic          q_pop;
   logic          q_push;
   logic [31:0]   ret_pc;
   logic [31:0]   head_ir;
   logic [31:0]   head_pc;
   logic [31:0]   head_pc4;

   // Credit rule: queued entries plus the outstanding fetch never exceed DEPTH.
   assign q_nonempty = (count != '0);
   assign issue      = !fq.w_halt && ((count + CW'(inflight)) < CW'(DEPTH));
   assign ret_valid  = inflight && !kill;
   assign ret_pc     = fetch_pc - 32'd4;

`ifdef IFETCH_BYPASS_EN
   assign bypass = ret_valid && !q_nonempty;
`else
   assign bypass = 1'b0;
`endif

   assign q_pop  = q_nonempty && fq.w_ready && !fq.w_redirect;
   assign q_push = ret_valid && !fq.w_redirect && !(bypass && fq.w_ready);

   always_comb begin
      head_ir  = NOP;
      head_pc  = last_pc;
      head_pc4 = last_pc4;
      if (q_nonempty) begin
         head_ir  = ir_q[head];
         head_pc  = pc_q[head];
         head_pc4 = pc4_q[head];
      end else if (bypass) begin
         head_ir  = fq.w_imem_data;
         head_pc  = ret_pc;
         head_pc4 = fetch_pc;
      end
   end

   assign fq.w_imem_addr = fetch_pc[AW+1:2];
   assign fq.w_imem_rd   = issue;
   assign fq.r_valid     = q_nonempty || bypass;
   assign fq.r_count     = count;
   assign fq.r_ir        = head_ir;
   assign fq.r_pc        = head_pc;
   assign fq.r_pc4       = head_pc4;

   // Redirect wins over everything: flush, retarget, and kill the fetch issued alongside it.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         fetch_pc <= RESET_PC;
         inflight <= 1'b0;
         kill     <= 1'b0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         last_pc  <= 32'h0;
         last_pc4 <= 32'h0;
      end else begin
         inflight <= issue;
         last_pc  <= head_pc;
         last_pc4 <= head_pc4;
         if (fq.w_redirect) begin
            fetch_pc <= fq.w_redirect_pc & 32'hFFFF_FFFC;
            kill     <= issue;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            kill  <= 1'b0;
            head  <= head + PW'(q_pop);
            tail  <= tail + PW'(q_push);
            count <= count + CW'(q_push) - CW'(q_pop);
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (q_push) begin
         ir_q[tail]  <= fq.w_imem_data;
         pc_q[tail]  <= ret_pc;
         pc4_q[tail] <= fetch_pc;
      end
   end
endmodule

// File: tb/tb_m_ifetch_queue.sv
// Directed bench for m_ifetch_queue with a 1-cycle imem model; honours IFETCH_BYPASS_EN.
module tb_m_ifetch_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 12;
`ifdef IFETCH_BYPASS_EN
   localparam int LAT      = 1;
   localparam int FIRST_CNT = 0;
`else
   localparam int LAT      = 2;
   localparam int FIRST_CNT = 1;
`endif

   logic        w_clk;
   logic        w_rst;
   logic        infl;
   logic [31:0] imem [64];
   int          total;
   int          bad;

   m_ifetch_queue_if #(.AW(AW), .DEPTH(DEPTH)) fq ();

   m_ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .AW(AW)) dut (
      .w_clk (w_clk),
      .w_rst (w_rst),
      .fq    (fq)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   always @(posedge w_clk) begin
      if (fq.w_imem_rd) fq.w_imem_data <= imem[fq.w_imem_addr[5:0]];
   end

   always @(posedge w_clk or posedge w_rst) begin
      if (w_rst) infl <= 1'b0;
      else       infl <= fq.w_imem_rd;
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic ready, input logic halt, input logic redir,
                                input logic [31:0] redir_pc);
      fq.w_ready       = ready;
      fq.w_halt        = halt;
      fq.w_redirect    = redir;
      fq.w_redirect_pc = redir_pc;
   endtask

   task automatic applyReset();
      w_rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge w_clk);
      @(negedge w_clk);
      w_rst = 1'b0;
   endtask

   // Queue plus outstanding fetch must never exceed the queue depth.
   always @(negedge w_clk) begin
      if (!w_rst)
         checkOutput("credit", {31'h0, (32'(fq.r_count) + 32'(infl)) <= 32'(DEPTH)}, 32'h1);
   end

   initial begin
      int issues;
      int seen40;
      int first_k;
      logic [31:0] first_pc;

      total = 0;
      bad   = 0;
      for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 | 32'(i);
      imem[0] = 32'h0000_0020;
      imem[1] = 32'h0000_0020;
      imem[2] = 32'h2014_1000;
      imem[3] = 32'h2015_000B;
      fq.w_imem_data = 32'h0;

      // reset state
      w_rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge w_clk);
      #2;
      checkOutput("rst_valid", {31'h0, fq.r_valid}, 32'h0);
      checkOutput("rst_count", 32'(fq.r_count), 32'h0);
      checkOutput("rst_ir", fq.r_ir, 32'h20);
      checkOutput("rst_pc", fq.r_pc, 32'h0);
      checkOutput("rst_pc4", fq.r_pc4, 32'h0);

      // streaming from reset with ready held high
      applyReset();
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
         #2;
         if (k < 4) begin
            checkOutput("s_rd", {31'h0, fq.w_imem_rd}, 32'h1);
            checkOutput("s_addr", 32'(fq.w_imem_addr), 32'(k));
         end
         if (k == LAT - 1) checkOutput("s_early_valid", {31'h0, fq.r_valid}, 32'h0);
         if (k == LAT) begin
            checkOutput("s_first_valid", {31'h0, fq.r_valid}, 32'h1);
            checkOutput("s_first_pc", fq.r_pc, 32'h0);
            checkOutput("s_first_count", 32'(fq.r_count), 32'(FIRST_CNT));
         end
         if (k == LAT + 2) begin
            checkOutput("s_ir8", fq.r_ir, 32'h2014_1000);
            checkOutput("s_pc8", fq.r_pc, 32'h8);
            checkOutput("s_pc4_8", fq.r_pc4, 32'hC);
         end
         @(negedge w_clk);
      end

      // back-pressure fills the queue, then drains in order
      applyReset();
      issues = 0;
      for (int k = 0; k < 15; k++) begin
         applyStimulus(k >= 10, 1'b0, 1'b0, 32'h0);
         #2;
         if (k < 10 && fq.w_imem_rd) issues++;
         if (k == 9) begin
            checkOutput("bp_rd_off", {31'h0, fq.w_imem_rd}, 32'h0);
            checkOutput("bp_count", 32'(fq.r_count), 32'h4);
            checkOutput("bp_issues", 32'(issues), 32'h4);
         end
         if (k >= 10 && k < 14) begin
            checkOutput("bp_valid", {31'h0, fq.r_valid}, 32'h1);
            checkOutput("bp_pc", fq.r_pc, 32'(4 * (k - 10)));
         end
         if (k == 11) begin
            checkOutput("bp_resume_rd", {31'h0, fq.w_imem_rd}, 32'h1);
            checkOutput("bp_resume_addr", 32'(fq.w_imem_addr), 32'h4);
         end
         if (k == 14) begin
            checkOutput("bp_pc16", fq.r_pc, 32'h10);
            checkOutput("bp_ir16", fq.r_ir, 32'hA000_0004);
         end
         @(negedge w_clk);
      end

      // redirect while the fetch of 0x40 is returning
      applyReset();
      seen40   = 0;
      first_k  = -1;
      first_pc = 32'hFFFF_FFFF;
      for (int k = 0; k < 25; k++) begin
         applyStimulus(1'b1, 1'b0, k == 17, 32'h24);
         #2;
         if (k == 16) checkOutput("rd_addr40", 32'(fq.w_imem_addr), 32'h10);
         if (k == 18) begin
            checkOutput("rd_flush_count", 32'(fq.r_count), 32'h0);
            checkOutput("rd_flush_valid", {31'h0, fq.r_valid}, 32'h0);
            checkOutput("rd_target_rd", {31'h0, fq.w_imem_rd}, 32'h1);
            checkOutput("rd_target_addr", 32'(fq.w_imem_addr), 32'h9);
         end
         if (k >= 18 && fq.r_valid) begin
            if (fq.r_pc == 32'h40) seen40++;
            if (first_k < 0) begin
               first_k  = k;
               first_pc = fq.r_pc;
            end
         end
         @(negedge w_clk);
      end
      checkOutput("rd_first_pc", first_pc, 32'h24);
      checkOutput("rd_first_cycle", 32'(first_k), 32'(18 + LAT));
      checkOutput("rd_killed_40", 32'(seen40), 32'h0);

      // halt with two queued and one in flight; redirect during halt; resume
      applyReset();
      for (int k = 0; k < 10; k++) begin
         applyStimulus(k >= 3, k >= 3 && k < 9, k == 7, 32'h33);
         #2;
         if (k == 3) checkOutput("h_count", 32'(fq.r_count), 32'h2);
         if (k >= 3 && k < 9) checkOutput("h_rd_off", {31'h0, fq.w_imem_rd}, 32'h0);
         if (k >= 3 && k < 6) begin
            checkOutput("h_valid", {31'h0, fq.r_valid}, 32'h1);
            checkOutput("h_pc", fq.r_pc, 32'(4 * (k - 3)));
         end
         if (k == 6) begin
            checkOutput("h_empty_valid", {31'h0, fq.r_valid}, 32'h0);
            checkOutput("h_empty_ir", fq.r_ir, 32'h20);
            checkOutput("h_hold_pc", fq.r_pc, 32'h8);
            checkOutput("h_hold_pc4", fq.r_pc4, 32'hC);
         end
         if (k == 9) begin
            checkOutput("h_resume_rd", {31'h0, fq.w_imem_rd}, 32'h1);
            checkOutput("h_resume_addr", 32'(fq.w_imem_addr), 32'hC);
         end
         @(negedge w_clk);
      end

      // asynchronous reset in the middle of a cycle with a full queue
      applyReset();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
         @(negedge w_clk);
      end
      #2;
      checkOutput("ar_full", 32'(fq.r_count), 32'h4);
      #1;
      w_rst = 1'b1;
      #1;
      checkOutput("ar_valid", {31'h0, fq.r_valid}, 32'h0);
      checkOutput("ar_count", 32'(fq.r_count), 32'h0);
      @(negedge w_clk);
      w_rst = 1'b0;
      for (int k = 0; k <= LAT; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
         #2;
         if (k == 0) checkOutput("ar_restart_addr", 32'(fq.w_imem_addr), 32'h0);
         if (k == LAT) checkOutput("ar_restart_pc", fq.r_pc, 32'h0);
         @(negedge w_clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
